// File: rtl/stdp_update_scheduler_pkg.sv
// Shared constants and types for the STDP update scheduler.
// Ages saturate at AGE_SAT, which means "no spike recent enough to matter".
package stdp_sched_pkg;

  localparam int N       = 16;
  localparam int SEL_W   = 4;
  localparam int DT_W    = 3;
  localparam int WINDOW  = 3;
  localparam int AGE_SAT = WINDOW + 1;
  localparam int AGE_W   = $clog2(AGE_SAT + 1);

  typedef logic signed [DT_W-1:0] dt_t;
  typedef logic [AGE_W-1:0]       age_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  localparam age_t AGE_WIN    = age_t'(WINDOW);
  localparam age_t AGE_SAT_V  = age_t'(AGE_SAT);

endpackage

// File: rtl/stdp_update_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// after ptr, wrapping at N. The pointer register lives in the parent.
module rr_arbiter
  import stdp_sched_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gntValid,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gntIdx
);

  always_comb begin
    int idx;
    // NOTE: every combinational output is assigned a default first, so no
    // path through the block leaves a value held and no latch is inferred.
    idx      = 0;
    gntValid = 1'b0;
    gnt      = '0;
    gntIdx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gntValid && req[idx]) begin
        gntValid = 1'b1;
        gnt[idx] = 1'b1;
        gntIdx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stdp_update_scheduler.sv
// Turns pre/post spike events into per-synapse STDP jobs and issues them one
// at a time, round-robin, to the shared weight datapath.
module stdp_update_scheduler
  import stdp_sched_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_tick,
  input  logic             post_spike,
  input  logic [N-1:0]     pre_spike,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [SEL_W-1:0] upd_sel,
  output logic [DT_W-1:0]  upd_dt,
  input  logic             upd_done,
  output logic             busy,
  output logic [7:0]       overrun_cnt
);

  state_t           state, stateNext;
  age_t             preAge [N];
  age_t             postAge;
  logic [N-1:0]     pend, pendNext;
  dt_t              pendDt [N];
  dt_t              pendDtNext [N];
  logic [SEL_W-1:0] ptr;
  logic [N-1:0]     setVec;
  dt_t              setDt [N];
  logic [N-1:0]     gnt, clr;
  logic             gntValid, doGrant;
  logic [SEL_W-1:0] gntIdx;
  logic [4:0]       ovInc;
  logic [8:0]       ovSum;

  rr_arbiter u_arb (
    .req      (pend),
    .ptr      (ptr),
    .gntValid (gntValid),
    .gnt      (gnt),
    .gntIdx   (gntIdx)
  );

  // Event evaluation uses the ages as they stood before this tick.
  always_comb begin
    setVec = '0;
    for (int i = 0; i < N; i++) begin
      setDt[i] = '0;
      if (spike_tick && enable) begin
        if (post_spike) begin
          if (pre_spike[i]) begin
            setVec[i] = 1'b1;
          end else if (preAge[i] < AGE_WIN) begin
            setVec[i] = 1'b1;
            setDt[i]  = dt_t'(preAge[i] + age_t'(1));
          end
        end else if (pre_spike[i] && (postAge < AGE_WIN)) begin
          setVec[i] = 1'b1;
          setDt[i]  = -dt_t'(postAge + age_t'(1));
        end
      end
    end
  end

  always_comb begin
    stateNext = state;
    doGrant   = 1'b0;
    upd_valid = 1'b0;
    case (state)
      IDLE: begin
        if (gntValid) begin
          doGrant   = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        upd_valid = 1'b1;
        if (upd_ready) stateNext = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (upd_done) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // A set on the entry being granted wins; the old job is already in flight,
  // so that overwrite is not an overrun.
  always_comb begin
    clr      = doGrant ? gnt : '0;
    pendNext = (pend & ~clr) | setVec;
    ovInc    = '0;
    for (int i = 0; i < N; i++) begin
      pendDtNext[i] = setVec[i] ? setDt[i] : pendDt[i];
      ovInc         = ovInc + 5'(setVec[i] & pend[i] & ~clr[i]);
    end
    ovSum = 9'(overrun_cnt) + 9'(ovInc);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments only,
      // so every register samples the pre-edge values of its neighbours.
      state <= stateNext;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      postAge <= AGE_SAT_V;
      for (int i = 0; i < N; i++) preAge[i] <= AGE_SAT_V;
    end else if (spike_tick) begin
      postAge <= post_spike ? '0 : ((postAge == AGE_SAT_V) ? AGE_SAT_V : postAge + age_t'(1));
      for (int i = 0; i < N; i++) begin
        preAge[i] <= pre_spike[i] ? '0
                   : ((preAge[i] == AGE_SAT_V) ? AGE_SAT_V : preAge[i] + age_t'(1));
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend        <= '0;
      ptr         <= '0;
      upd_sel     <= '0;
      upd_dt      <= '0;
      busy        <= 1'b0;
      overrun_cnt <= '0;
      // NOTE: the dt table is small and reset explicitly so a freshly granted
      // entry can never expose an unknown value on upd_dt.
      for (int i = 0; i < N; i++) pendDt[i] <= '0;
    end else begin
      pend        <= pendNext;
      busy        <= (stateNext != IDLE) | (|pendNext);
      overrun_cnt <= (ovSum > 9'd255) ? 8'hFF : ovSum[7:0];
      for (int i = 0; i < N; i++) pendDt[i] <= pendDtNext[i];
      if (doGrant) begin
        upd_sel <= gntIdx;
        upd_dt  <= pendDt[gntIdx];
        ptr     <= gntIdx + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Scoreboard bench: expected jobs are queued as spikes are driven and popped
// when the datapath model accepts a job.
module tb_stdp_update_scheduler;
  import stdp_sched_pkg::*;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             spike_tick = 1'b0;
  logic             post_spike = 1'b0;
  logic [N-1:0]     pre_spike = '0;
  logic             upd_valid;
  logic             upd_ready = 1'b0;
  logic [SEL_W-1:0] upd_sel;
  logic [DT_W-1:0]  upd_dt;
  logic             upd_done = 1'b0;
  logic             busy;
  logic [7:0]       overrun_cnt;

  typedef struct {
    int sel;
    int dt;
  } job_t;

  job_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   doneDelay = 0;

  stdp_update_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .spike_tick  (spike_tick),
    .post_spike  (post_spike),
    .pre_spike   (pre_spike),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_sel     (upd_sel),
    .upd_dt      (upd_dt),
    .upd_done    (upd_done),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pushJob(input int sel, input int dt);
    job_t j;
    j.sel = sel;
    j.dt  = dt;
    expQ.push_back(j);
  endtask

  // Datapath model: sample away from the rising edge, answer upd_done two
  // cycles after each accepted job.
  always @(negedge clock) begin
    job_t j;
    upd_done = 1'b0;
    if (doneDelay > 0) begin
      doneDelay--;
      if (doneDelay == 0) upd_done = 1'b1;
    end
    if (reset && upd_valid && upd_ready) begin
      check("job expected", int'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        j = expQ.pop_front();
        check("job sel", int'(upd_sel), j.sel);
        check("job dt", int'($signed(upd_dt)), j.dt);
      end
      doneDelay = 2;
    end
  end

  task automatic tick(input logic post, input logic [N-1:0] pre);
    @(posedge clock); #1;
    spike_tick = 1'b1;
    post_spike = post;
    pre_spike  = pre;
    @(posedge clock); #1;
    spike_tick = 1'b0;
    post_spike = 1'b0;
    pre_spike  = '0;
  endtask

  task automatic flush();
    repeat (4) tick(1'b0, '0);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    repeat (3) @(posedge clock);
    #1;
    while ((busy || doneDelay != 0 || expQ.size() != 0) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " jobs left"}, expQ.size(), 0);
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!upd_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, int'(upd_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset valid", int'(upd_valid), 0);
    check("reset busy", int'(busy), 0);
    reset  = 1'b1;
    enable = 1'b1;

    // Reset mid-ISSUE with an overrun already recorded.
    tick(1'b0, 16'h0050);
    tick(1'b1, '0);
    waitValid("rst issue valid");
    check("rst issue sel", int'(upd_sel), 4);
    tick(1'b1, 16'h0050);
    check("rst pre overrun", int'(overrun_cnt), 1);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("rst async valid", int'(upd_valid), 0);
    check("rst async busy", int'(busy), 0);
    check("rst async overrun", int'(overrun_cnt), 0);
    check("rst async sel", int'(upd_sel), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    upd_ready = 1'b1;
    tick(1'b1, '0);
    waitIdle("post reset");

    // LTP: pre two ticks before post.
    flush();
    pushJob(1, 2);
    tick(1'b0, 16'h0002);
    tick(1'b0, '0);
    tick(1'b1, '0);
    waitIdle("ltp");

    // LTD: post one tick before pre.
    flush();
    pushJob(3, -1);
    tick(1'b1, '0);
    tick(1'b0, 16'h0008);
    waitIdle("ltd");

    // Simultaneous pre and post.
    flush();
    pushJob(2, 0);
    tick(1'b1, 16'h0004);
    waitIdle("simul");

    // Pre four ticks before post is outside the window.
    flush();
    tick(1'b0, 16'h0100);
    repeat (3) tick(1'b0, '0);
    tick(1'b1, '0);
    waitIdle("out of window");

    // Single job on synapse 5 leaves the pointer at 6.
    flush();
    pushJob(5, 1);
    tick(1'b0, 16'h0020);
    tick(1'b1, '0);
    waitIdle("ptr setup");

    // Round robin from pointer 6.
    flush();
    pushJob(15, 1);
    pushJob(0, 1);
    pushJob(5, 1);
    tick(1'b0, 16'h8021);
    tick(1'b1, '0);
    waitIdle("round robin");

    // Backpressure and overrun; pointer 6 means synapse 7 wins first.
    flush();
    upd_ready = 1'b0;
    pushJob(7, 1);
    tick(1'b0, 16'h0280);
    tick(1'b1, '0);
    waitValid("stall valid");
    check("stall sel a", int'(upd_sel), 7);
    check("stall dt a", int'($signed(upd_dt)), 1);
    pushJob(9, 2);
    pushJob(7, 2);
    tick(1'b1, '0);
    repeat (3) @(posedge clock);
    #1;
    check("stall sel b", int'(upd_sel), 7);
    check("stall dt b", int'($signed(upd_dt)), 1);
    check("stall valid b", int'(upd_valid), 1);
    check("overrun one", int'(overrun_cnt), 1);
    upd_ready = 1'b1;
    waitIdle("backpressure");

    // Learning disabled on an in-window post; ages still advance.
    flush();
    tick(1'b0, 16'h0400);
    enable = 1'b0;
    tick(1'b1, '0);
    waitIdle("disabled");
    enable = 1'b1;
    pushJob(10, 2);
    tick(1'b1, '0);
    waitIdle("re-enabled");

    check("final overrun", int'(overrun_cnt), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
